// File: rtl/phaser_seq_pkg.sv
// Shared definitions for the phaser reference lock sequencer: state encoding,
// default timing parameters and counter sizing helpers.
package phaser_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PWRDN     = 3'd1,
    ST_RESET     = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_QUALIFY   = 3'd4,
    ST_READY     = 3'd5,
    ST_FAILED    = 3'd6
  } seq_state_e;

  localparam int DEF_PWRDWN_CYCLES = 8;
  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 4096;
  localparam int DEF_STABLE_CYCLES = 64;
  localparam int DEF_MAX_RETRIES   = 3;

  localparam int                 RETRY_W   = 4;
  localparam logic [RETRY_W-1:0] RETRY_SAT = 4'hF;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer with synchronous active-low reset to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/phaser_lock_seq.sv
// Power-down / reset / lock-qualify sequencer for a phaser reference, with
// bounded retries and a sticky failure flag. All outputs are registered.
module phaser_lock_seq
  import phaser_seq_pkg::*;
#(
  parameter int PWRDWN_CYCLES = DEF_PWRDWN_CYCLES,
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               ENABLE,
  input  logic               LOCKED_IN,
  output logic               PWRDWN_OUT,
  output logic               RST_OUT,
  output logic               READY,
  output logic               LOCK_LOST,
  output logic               FAIL,
  output logic [RETRY_W-1:0] RETRY_CNT,
  output seq_state_e         DBG_STATE
);

  localparam int CNT_W = cnt_width(max_of4(PWRDWN_CYCLES, RST_CYCLES,
                                           LOCK_TIMEOUT, STABLE_CYCLES));

  localparam logic [CNT_W-1:0] PWRDN_LAST   = CNT_W'(PWRDWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pwrdn_q, pwrdn_d;
  logic               rst_q, rst_d;
  logic               ready_q, ready_d;
  logic               lost_q, lost_d;
  logic               fail_q, fail_d;

  logic               lk;
  logic               attempt_failed;
  logic [RETRY_W-1:0] retry_inc;

  sync_2ff u_lock_sync (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .d_i    (LOCKED_IN),
    .q_o    (lk)
  );

  assign retry_inc = (retry_q == RETRY_SAT) ? retry_q : retry_q + RETRY_W'(1);

  always_comb begin
    state_d        = state_q;
    retry_d        = retry_q;
    lost_d         = 1'b0;
    attempt_failed = 1'b0;

    case (state_q)
      ST_IDLE:      state_d = ST_PWRDN;
      ST_PWRDN:     if (cnt_q == PWRDN_LAST) state_d = ST_RESET;
      ST_RESET:     if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lk) state_d = ST_QUALIFY;
        else if (cnt_q == TIMEOUT_LAST) attempt_failed = 1'b1;
      end
      ST_QUALIFY: begin
        if (!lk) attempt_failed = 1'b1;
        else if (cnt_q == STABLE_LAST) state_d = ST_READY;
      end
      ST_READY: begin
        if (!lk) begin
          attempt_failed = 1'b1;
          lost_d         = 1'b1;
        end
      end
      ST_FAILED:    state_d = ST_FAILED;
      default:      state_d = ST_IDLE;
    endcase

    // Every failed attempt is charged here so all three failure paths agree.
    if (attempt_failed) begin
      retry_d = retry_inc;
      state_d = (int'(retry_inc) > MAX_RETRIES) ? ST_FAILED : ST_PWRDN;
    end

    // Dropping ENABLE wins over everything and wipes the retry history.
    if (!ENABLE) begin
      state_d = ST_IDLE;
      retry_d = '0;
      lost_d  = 1'b0;
    end

    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q inside {ST_PWRDN, ST_RESET, ST_WAIT_LOCK, ST_QUALIFY}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Outputs are decoded from the next state so they line up with state_q.
    pwrdn_d = (state_d inside {ST_IDLE, ST_PWRDN, ST_FAILED});
    rst_d   = (state_d inside {ST_IDLE, ST_PWRDN, ST_RESET, ST_FAILED});
    ready_d = (state_d == ST_READY);
    fail_d  = (state_d == ST_FAILED);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
      pwrdn_q <= 1'b1;
      rst_q   <= 1'b1;
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      pwrdn_q <= pwrdn_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      lost_q  <= lost_d;
      fail_q  <= fail_d;
    end
  end

  assign PWRDWN_OUT = pwrdn_q;
  assign RST_OUT    = rst_q;
  assign READY      = ready_q;
  assign LOCK_LOST  = lost_q;
  assign FAIL       = fail_q;
  assign RETRY_CNT  = retry_q;
  assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_phaser_lock_seq.sv
// Self-checking bench for phaser_lock_seq: directed scenarios plus a random
// phase, all checked every cycle against an attempt-timeline reference model.
module tb_phaser_lock_seq;
  import phaser_seq_pkg::*;

  localparam int P    = 8;
  localparam int R    = 16;
  localparam int T    = 4096;
  localparam int S    = 64;
  localparam int MAXR = 3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       locked_in;
  logic       pwrdwn_out;
  logic       rst_out;
  logic       ready;
  logic       lock_lost;
  logic       fail;
  logic [3:0] retry_cnt;
  seq_state_e dbg_state;

  always #5 clk = ~clk;

  phaser_lock_seq #(
    .PWRDWN_CYCLES (P),
    .RST_CYCLES    (R),
    .LOCK_TIMEOUT  (T),
    .STABLE_CYCLES (S),
    .MAX_RETRIES   (MAXR)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .ENABLE     (enable),
    .LOCKED_IN  (locked_in),
    .PWRDWN_OUT (pwrdwn_out),
    .RST_OUT    (rst_out),
    .READY      (ready),
    .LOCK_LOST  (lock_lost),
    .FAIL       (fail),
    .RETRY_CNT  (retry_cnt),
    .DBG_STATE  (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Mode: 0 idle, 1 running an attempt, 2 given up. Within an attempt m_t counts
  // cycles since the attempt began; once past power-down+reset, m_w counts
  // waiting cycles and m_s counts qualifying cycles (0 = not yet locked).
  int m_mode  = 0;
  int m_t     = 0;
  int m_w     = 0;
  int m_s     = 0;
  int m_retry = 0;
  bit m_rdy   = 1'b0;
  bit m_lost  = 1'b0;
  bit lk_hist[$];

  task automatic model_fail_attempt();
    m_retry = (m_retry >= 15) ? 15 : m_retry + 1;
    m_rdy   = 1'b0;
    if (m_retry > MAXR) begin
      m_mode = 2;
    end else begin
      m_t = 0;
      m_w = 0;
      m_s = 0;
    end
  endtask

  always @(posedge clk) begin
    bit lk;
    // LK seen at an edge is LOCKED_IN as sampled two edges earlier.
    if (!rst_n) begin
      lk_hist = '{1'b0, 1'b0};
      lk      = 1'b0;
    end else begin
      lk = lk_hist.pop_front();
      lk_hist.push_back(locked_in);
    end
    m_lost = 1'b0;
    if (!rst_n || !enable) begin
      m_mode  = 0;
      m_retry = 0;
      m_rdy   = 1'b0;
    end else if (m_mode == 0) begin
      m_mode = 1;
      m_t    = 0;
      m_w    = 0;
      m_s    = 0;
    end else if (m_mode == 1) begin
      if (m_t < P + R) begin
        m_t++;
      end else if (m_rdy) begin
        if (!lk) begin
          m_lost = 1'b1;
          model_fail_attempt();
        end
      end else if (m_s > 0) begin
        if (!lk) model_fail_attempt();
        else if (m_s == S) m_rdy = 1'b1;
        else m_s++;
      end else begin
        if (lk) m_s = 1;
        else if (m_w == T - 1) model_fail_attempt();
        else m_w++;
      end
    end
  end

  // ---------------- scoreboard: per-cycle comparison ----------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_pwrdwn", pwrdwn_out, (m_mode != 1 || m_t < P) ? 1 : 0);
      chk("cyc_rst",    rst_out,    (m_mode != 1 || m_t < P + R) ? 1 : 0);
      chk("cyc_ready",  ready,      (m_mode == 1 && m_rdy) ? 1 : 0);
      chk("cyc_lost",   lock_lost,  m_lost);
      chk("cyc_fail",   fail,       (m_mode == 2) ? 1 : 0);
      chk("cyc_retry",  retry_cnt,  m_retry);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_pwrdwn"}, pwrdwn_out, 1);
    chk({tag, "_rst"},    rst_out,    1);
    chk({tag, "_ready"},  ready,      0);
    chk({tag, "_lost"},   lock_lost,  0);
    chk({tag, "_fail"},   fail,       0);
    chk({tag, "_retry"},  retry_cnt,  0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int pulses;
    rst_n     = 1'b0;
    enable    = 1'b0;
    locked_in = 1'b0;
    cyc(3);
    chk_reset_values("por");
    check_en = 1'b1;
    rst_n    = 1'b1;
    cyc(2);

    // Clean bring-up: lock arrives 100 cycles into the wait.
    enable = 1'b1;
    n = 0;
    do begin
      cyc(1);
      if (pwrdwn_out) n++;
    end while (pwrdwn_out && n < 100);
    chk("a_pwrdn_len", n, P);
    n = 0;
    while (rst_out && n < 100) begin
      n++;
      cyc(1);
    end
    chk("a_rst_len", n, R);
    cyc(99);
    locked_in = 1'b1;
    n = 0;
    while (!ready && n < 300) begin
      cyc(1);
      n++;
    end
    // 2 synchronizer cycles, 1 wait-state decision, then STABLE_CYCLES.
    chk("a_ready_lat", n, 2 + 1 + S);
    chk("a_retry", retry_cnt, 0);

    // Lock drops while ready, then returns.
    cyc(20);
    locked_in = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (lock_lost) pulses++;
    end
    chk("b_lost_pulses", pulses, 1);
    chk("b_ready_low", ready, 0);
    chk("b_retry", retry_cnt, 1);
    locked_in = 1'b1;
    n = 0;
    while (!ready && n < 500) begin
      cyc(1);
      n++;
    end
    chk("b_relock_ready", ready, 1);
    chk("b_relock_retry", retry_cnt, 1);

    // Glitch at qualify cycle 30 after an ENABLE toggle clears the count.
    enable    = 1'b0;
    locked_in = 1'b0;
    cyc(2);
    chk("c_clear_retry", retry_cnt, 0);
    enable = 1'b1;
    n = 0;
    while (rst_out && n < 200) begin
      cyc(1);
      n++;
    end
    chk("c_reset_done", rst_out, 0);
    cyc(5);
    locked_in = 1'b1;
    cyc(30);
    locked_in = 1'b0;
    cyc(1);
    locked_in = 1'b1;
    cyc(4);
    chk("c_no_ready", ready, 0);
    chk("c_retry", retry_cnt, 1);
    chk("c_repwrdn", pwrdwn_out, 1);
    cyc(150);

    // Lock never comes: four timeouts then sticky failure.
    enable    = 1'b0;
    locked_in = 1'b0;
    cyc(2);
    enable = 1'b1;
    n = 0;
    while (!fail && n < 20000) begin
      cyc(1);
      n++;
    end
    chk("d_fail_lat", n, 1 + (MAXR + 1) * (P + R + T));
    chk("d_retry", retry_cnt, MAXR + 1);
    chk("d_pwrdwn", pwrdwn_out, 1);
    cyc(50);
    chk("d_fail_sticky", fail, 1);
    chk("d_pwrdwn_held", pwrdwn_out, 1);

    // Leave FAILED via ENABLE, then reset in the middle of RESET.
    enable = 1'b0;
    cyc(1);
    chk("e_fail_clr", fail, 0);
    chk("e_retry_clr", retry_cnt, 0);
    enable = 1'b1;
    n = 0;
    while (!( !pwrdwn_out && rst_out) && n < 100) begin
      cyc(1);
      n++;
    end
    chk("e_in_reset_phase", {pwrdwn_out, rst_out}, 2'b01);
    cyc(3);
    rst_n = 1'b0;
    cyc(1);
    chk_reset_values("e_mid_rst");
    rst_n = 1'b1;
    cyc(3);

    // Random phase: long lock holds, short ENABLE/reset drops.
    for (int seg = 0; seg < 120; seg++) begin
      int len;
      len       = $urandom_range(1, 120);
      locked_in = ($urandom_range(0, 9) < 7);
      enable    = ($urandom_range(0, 19) != 0);
      rst_n     = ($urandom_range(0, 39) != 0);
      if (!enable || !rst_n) len = $urandom_range(1, 3);
      cyc(len);
      rst_n  = 1'b1;
      enable = 1'b1;
    end
    cyc(5);
    check_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phaser_lock_seq.md
PHASER_LOCK_SEQ -- requirements
Module: phaser_lock_seq

Interface
REQ-001 The block SHALL have parameter PWRDWN_CYCLES, default 8: cycles PWRDWN_OUT is held high per attempt.
REQ-002 The block SHALL have parameter RST_CYCLES, default 16: cycles RST_OUT is held high after power-down.
REQ-003 The block SHALL have parameter LOCK_TIMEOUT, default 4096: cycles allowed for synchronized LOCKED to rise.
REQ-004 The block SHALL have parameter STABLE_CYCLES, default 64: consecutive high cycles of synchronized LOCKED required before READY.
REQ-005 The block SHALL have parameter MAX_RETRIES, default 3: failed attempts tolerated before FAIL.
REQ-006 The block SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port RST_N, input, 1 bit: reset, synchronous and active-low.
REQ-008 The block SHALL have port ENABLE, input, 1 bit: start or keep the sequence running; low forces power-down.
REQ-009 The block SHALL have port LOCKED_IN, input, 1 bit: phaser reference LOCKED, asynchronous to CLK.
REQ-010 The block SHALL have port PWRDWN_OUT, output, 1 bit: drives phaser reference PWRDWN.
REQ-011 The block SHALL have port RST_OUT, output, 1 bit: drives phaser reference RST.
REQ-012 The block SHALL have port READY, output, 1 bit: high while lock is qualified.
REQ-013 The block SHALL have port LOCK_LOST, output, 1 bit: one-cycle pulse when qualified lock drops.
REQ-014 The block SHALL have port FAIL, output, 1 bit: sticky; set when the retry budget is exhausted.
REQ-015 The block SHALL have port RETRY_CNT, output, 4 bits: number of failed attempts since the last reset or ENABLE rise; saturates at 15.

Function
REQ-016 LOCKED_IN SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value LK.
REQ-017 The state machine SHALL have the states IDLE, PWRDN, RESET, WAIT_LOCK, QUALIFY, READY and FAILED.
REQ-018 IDLE: PWRDWN_OUT=1 and RST_OUT=1; the next cycle with ENABLE=1 SHALL go to PWRDN.
REQ-019 PWRDN: PWRDWN_OUT=1 and RST_OUT=1 for exactly PWRDWN_CYCLES cycles, then RESET.
REQ-020 RESET: PWRDWN_OUT=0 and RST_OUT=1 for exactly RST_CYCLES cycles, then WAIT_LOCK.
REQ-021 WAIT_LOCK: both outputs low; LK=1 SHALL go to QUALIFY; LOCK_TIMEOUT cycles without LK SHALL count as a failed attempt.
REQ-022 QUALIFY: STABLE_CYCLES consecutive cycles of LK=1 SHALL go to READY; any LK=0 SHALL count as a failed attempt.
REQ-023 On a failed attempt, RETRY_CNT SHALL increment; if the new value exceeds MAX_RETRIES the next state SHALL be FAILED, otherwise PWRDN.
REQ-024 READY: READY=1; LK=0 SHALL pulse LOCK_LOST for one cycle, clear READY in that same cycle, increment RETRY_CNT and go to PWRDN, or to FAILED per REQ-023.
REQ-025 FAILED: FAIL=1 and PWRDWN_OUT=1; exit SHALL occur only via reset or ENABLE falling.
REQ-026 ENABLE=0 in any state SHALL go to IDLE on the next cycle and clear READY.
REQ-027 ENABLE=0 SHALL clear FAIL and RETRY_CNT, and this SHALL take priority over every other transition.
REQ-028 A single shared cycle counter SHALL be used, cleared on every state entry and wide enough for the largest parameter.
REQ-029 READY SHALL rise exactly STABLE_CYCLES cycles after the first QUALIFY cycle.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 When RST_N=0 on a rising CLK edge, the state SHALL become IDLE.
REQ-032 Reset SHALL set PWRDWN_OUT=1 and RST_OUT=1.
REQ-033 Reset SHALL set READY=0, LOCK_LOST=0, FAIL=0 and RETRY_CNT=0.
REQ-034 Reset SHALL clear the counter and the synchronizer flops to 0.
REQ-035 Reset applied mid-sequence SHALL override every transition.

Structure
REQ-036 The state encoding and default parameter values SHALL live in the shared package phaser_seq_pkg.
REQ-037 The synchronizer SHALL be the sub-module sync_2ff, one bit wide and reset to 0.

Verification
REQ-038 ENABLE=1, LOCKED_IN rises 100 cycles after RST_OUT falls and stays high -> PWRDWN_OUT high 8 cycles, RST_OUT high 16 more cycles, READY=1 exactly 64 cycles after LK rises, RETRY_CNT=0.
REQ-039 LOCKED_IN never rises -> four timeouts of 4096 cycles each, RETRY_CNT=4, FAIL=1, PWRDWN_OUT=1 held.
REQ-040 LOCKED_IN glitches low at QUALIFY cycle 30 -> no READY, RETRY_CNT=1, re-entry to PWRDN.
REQ-041 In READY, LOCKED_IN drops -> LOCK_LOST pulses exactly one cycle, READY=0, RETRY_CNT=1, the sequence restarts, and READY returns once lock is re-qualified.
REQ-042 In FAILED, ENABLE goes low then high -> FAIL=0, RETRY_CNT=0, a fresh sequence starts; RST_N=0 asserted during RESET -> IDLE with all reset values.
